// File: rtl/multi_alarm_timekeeper.sv
// 12/24-hour clock with NUM_ALARMS independent alarms, snooze, auto-stop and a gated buzzer.
// Adjust pulses take priority over the second tick, which is deferred one cycle.
module multi_alarm_timekeeper #(
  parameter int CLK_HZ       = 31500000,
  parameter int NUM_ALARMS   = 4,
  parameter bit H24          = 1'b0,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_MAX_MIN = 10,
  parameter int BUZZ_DIV     = 5000,
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sec_inc,
  input  logic                  min_inc,
  input  logic                  hr_inc,
  input  logic [AW-1:0]         al_sel,
  input  logic                  al_min_inc,
  input  logic                  al_hr_inc,
  input  logic                  al_toggle,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [4:0]            hours,
  output logic [5:0]            minutes,
  output logic [5:0]            seconds,
  output logic                  sec_tick,
  output logic [NUM_ALARMS-1:0] al_en,
  output logic [4:0]            al_hours_rd,
  output logic [5:0]            al_minutes_rd,
  output logic                  ringing,
  output logic                  snoozed,
  output logic [AW-1:0]         ring_idx,
  output logic                  buzzer
);
  localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SNZ_LOAD = SNOOZE_MIN * 60;
  localparam int SW       = (SNZ_LOAD > 0) ? $clog2(SNZ_LOAD + 1) : 1;
  localparam int RW       = (RING_MAX_MIN > 0) ? $clog2(RING_MAX_MIN + 1) : 1;
  localparam int BW       = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [4:0] HMAX = H24 ? 5'd23 : 5'd11;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  logic [PW-1:0]                 presc;
  logic                          pend;
  logic                          sec0_evt;
  logic                          adj, tick_due, tick_apply, roll_min;
  logic                          al_ok;
  logic [NUM_ALARMS-1:0][4:0]    al_hr;
  logic [NUM_ALARMS-1:0][5:0]    al_mn;
  logic                          hit, match;
  logic [AW-1:0]                 match_idx;
  logic                          en_lost;
  state_t                        state;
  logic [SW-1:0]                 snz_cnt;
  logic [RW-1:0]                 ring_min;
  logic [BW-1:0]                 bdiv;
  logic                          bsq;

  assign sec_tick   = (presc == PW'(CLK_HZ - 1));
  assign adj        = sec_inc | min_inc | hr_inc;
  assign tick_due   = sec_tick | pend;
  assign tick_apply = tick_due & ~adj;
  assign roll_min   = tick_apply & (seconds == 6'd59);
  assign al_ok      = (int'(al_sel) < NUM_ALARMS);

  // Timekeeping: adjusts never carry; a tick colliding with an adjust waits one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      pend     <= 1'b0;
      sec0_evt <= 1'b0;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
    end else begin
      presc    <= (sec_inc || sec_tick) ? '0 : presc + 1'b1;
      pend     <= tick_due & adj & ~sec_inc;
      sec0_evt <= sec_inc | roll_min;
      if (adj) begin
        if (sec_inc) seconds <= '0;
        if (min_inc) minutes <= (minutes == 6'd59) ? '0 : minutes + 6'd1;
        if (hr_inc)  hours   <= (hours == HMAX) ? '0 : hours + 5'd1;
      end else if (tick_apply) begin
        if (seconds == 6'd59) begin
          seconds <= '0;
          if (minutes == 6'd59) begin
            minutes <= '0;
            hours   <= (hours == HMAX) ? '0 : hours + 5'd1;
          end else begin
            minutes <= minutes + 6'd1;
          end
        end else begin
          seconds <= seconds + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      al_hr <= '0;
      al_mn <= '0;
      al_en <= '0;
    end else begin
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (al_ok && int'(al_sel) == k) begin
          if (al_hr_inc)  al_hr[k] <= (al_hr[k] == HMAX) ? '0 : al_hr[k] + 5'd1;
          if (al_min_inc) al_mn[k] <= (al_mn[k] == 6'd59) ? '0 : al_mn[k] + 6'd1;
          if (al_toggle)  al_en[k] <= ~al_en[k];
        end
      end
    end
  end

  always_comb begin
    al_hours_rd   = '0;
    al_minutes_rd = '0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      if (al_ok && int'(al_sel) == k) begin
        al_hours_rd   = al_hr[k];
        al_minutes_rd = al_mn[k];
      end
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    hit       = 1'b0;
    match_idx = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
      if (al_en[k] && al_hr[k] == hours && al_mn[k] == minutes) begin
        hit       = 1'b1;
        match_idx = AW'(k);
      end
    end
  end

  assign match   = sec0_evt & hit;
  assign en_lost = al_toggle & al_ok & (al_sel == ring_idx) & al_en[ring_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ring_idx <= '0;
      snz_cnt  <= '0;
      ring_min <= '0;
      bdiv     <= '0;
      bsq      <= 1'b1;
    end else begin
      // Divider parks at its restart value outside RINGING, so every entry starts a fresh high phase.
      if (state == RINGING) begin
        if (bdiv == BW'(BUZZ_DIV - 1)) begin
          bdiv <= '0;
          bsq  <= ~bsq;
        end else begin
          bdiv <= bdiv + 1'b1;
        end
      end else begin
        bdiv <= '0;
        bsq  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (match) begin
            state    <= RINGING;
            ring_idx <= match_idx;
            ring_min <= '0;
          end
        end
        RINGING: begin
          if (dismiss || en_lost) begin
            state <= IDLE;
          end else if (snooze) begin
            state   <= SNOOZED;
            snz_cnt <= SW'(SNZ_LOAD);
          end else if (roll_min) begin
            if (int'(ring_min) + 1 >= RING_MAX_MIN) state <= IDLE;
            else ring_min <= ring_min + 1'b1;
          end
        end
        SNOOZED: begin
          if (dismiss || en_lost) begin
            state <= IDLE;
          end else if (tick_apply) begin
            if (snz_cnt <= SW'(1)) begin
              state    <= RINGING;
              ring_min <= '0;
              snz_cnt  <= '0;
            end else begin
              snz_cnt <= snz_cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ringing = (state == RINGING);
  assign snoozed = (state == SNOOZED);
  assign buzzer  = ringing & bsq & ~seconds[0];

endmodule

// File: doc/multi_alarm_timekeeper.md
MULTI_ALARM_TIMEKEEPER -- requirements
Module: multi_alarm_timekeeper

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
  - CLK_HZ, 31500000, clk frequency; one second = CLK_HZ cycles.
  - NUM_ALARMS, 4, number of independent alarms (1..16).
  - H24, 0, hour range 0..11 when 0, 0..23 when 1.
  - SNOOZE_MIN, 5, snooze length in minutes.
  - RING_MAX_MIN, 10, auto-stop after this many minutes of continuous RINGING.
  - BUZZ_DIV, 5000, buzzer half-period in clk cycles.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning); AW = max(1, clog2(NUM_ALARMS)):
  - clk, in, 1, clock; reset, in, 1, reset, synchronous, active-high.
  - sec_inc / min_inc / hr_inc, in, 1 each, one-cycle debounced adjust pulses.
  - al_sel, in, AW, selected alarm; al_min_inc / al_hr_inc / al_toggle, in, 1 each, pulses acting on al_sel.
  - snooze / dismiss, in, 1 each, one-cycle pulses.
  - hours, out, 5; minutes, out, 6; seconds, out, 6, current time.
  - sec_tick, out, 1, one-cycle pulse per elapsed second.
  - al_en, out, NUM_ALARMS, per-alarm enable.
  - al_hours_rd, out, 5; al_minutes_rd, out, 6, readback of selected alarm.
  - ringing, out, 1; snoozed, out, 1; ring_idx, out, AW; buzzer, out, 1.

Function
REQ-003 Prescaler SHALL count 0..CLK_HZ-1 and assert sec_tick for exactly the cycle it equals CLK_HZ-1, then wrap to 0.
REQ-004 On an applied tick the time SHALL update as follows:
  - seconds 59->0 carries into minutes; minutes 59->0 carries into hours.
  - hours wrap HMAX->0, where HMAX = 23 if H24 else 11.
  - All updates are visible the cycle after the tick.
REQ-005 sec_inc SHALL clear seconds and the prescaler; min_inc SHALL add 1 to minutes mod 60; hr_inc SHALL add 1 to hours mod (HMAX+1).
REQ-006 Adjust pulses SHALL never carry into higher fields.
REQ-007 If an adjust pulse and sec_tick coincide, the adjust SHALL apply and the tick SHALL be held pending and applied the next cycle. Exception: sec_inc discards the pending tick.
REQ-008 Multiple simultaneous adjust pulses SHALL all apply in the same cycle.
REQ-009 Alarm registers SHALL be written only when al_sel < NUM_ALARMS; otherwise writes are ignored and readback is 0.
  - al_min_inc adds 1 mod 60; al_hr_inc adds 1 mod (HMAX+1).
  - al_toggle inverts al_en[al_sel].
REQ-010 Readback SHALL be combinational from al_sel.
REQ-011 A match event SHALL occur on the cycle after time updates to seconds==0, if some alarm k has al_en[k]=1, hours==al_hours[k] and minutes==al_minutes[k]. Adjust-induced seconds==0 also qualifies.
REQ-012 When several alarms match, the lowest index SHALL win.
REQ-013 The alarm FSM SHALL have states IDLE, RINGING and SNOOZED. Transitions:
  - IDLE: on match -> RINGING, latch ring_idx=k, clear ring-minute counter.
  - RINGING: dismiss -> IDLE.
  - RINGING: snooze -> SNOOZED, load snooze counter with SNOOZE_MIN*60.
  - RINGING: ring-minute counter (incremented on each seconds 59->0) reaching RING_MAX_MIN -> IDLE.
  - SNOOZED: counter decrements on each applied tick; at 0 -> RINGING with ring-minute counter cleared.
  - SNOOZED: dismiss -> IDLE.
REQ-014 Alarm FSM boundary conditions SHALL be handled as follows:
  - dismiss and snooze coincident: dismiss wins.
  - Matches while not IDLE are ignored.
  - al_toggle clearing al_en[ring_idx] while RINGING or SNOOZED -> IDLE.
REQ-015 ringing SHALL be 1 only in RINGING, snoozed SHALL be 1 only in SNOOZED, and ring_idx SHALL hold its last value in IDLE.
REQ-016 buzzer SHALL be a square wave toggling every BUZZ_DIV cycles, gated to 0 unless ringing=1 and seconds[0]=0. Its divider SHALL restart on entry to RINGING.

Reset
REQ-017 Reset SHALL clear:
  - prescaler, time, pending tick;
  - all alarm times and al_en;
  - FSM to IDLE, ring_idx, snooze and ring-minute counters;
  - buzzer and sec_tick.
REQ-018 Reset mid-RINGING or mid-SNOOZED SHALL force buzzer=0 and ringing=0 the cycle after reset is sampled.

Verification
REQ-019 CLK_HZ=10, H24=0, time 11:59:59, one tick -> 00:00:00 one cycle later; with H24=1 and 23:59:59 -> 00:00:00.
REQ-020 min_inc coincident with sec_tick at 10:20:59 -> 10:21:59 next cycle, then 10:22:00 the cycle after (pending tick applied, carry from seconds).
REQ-021 Alarms 1 and 3 enabled, both at 07:30, time reaches 07:30:00 -> ringing=1 with ring_idx=1 one cycle later; buzzer toggles every BUZZ_DIV cycles only during even seconds.
REQ-022 Snooze with SNOOZE_MIN=1 -> snoozed=1, ringing=0; 60 ticks later -> ringing=1. Then snooze and dismiss in the same cycle -> IDLE, buzzer=0.
REQ-023 RING_MAX_MIN=2, ring left unattended -> IDLE after the second minute rollover. Then al_sel=NUM_ALARMS with al_min_inc -> no alarm changes and readback 0.
REQ-024 Reset asserted while RINGING at 07:30:05 -> time 00:00:00, al_en all 0, ringing=0, buzzer=0 the next cycle.
